// File: rtl/irq_ctrl_multi.sv
// N-channel interrupt controller: latches edge/level requests, arbitrates one winner, tracks one handler.
// Optional macro IRQ_PRIO_RR_EN selects round-robin arbitration instead of fixed lowest-index priority.
module irq_ctrl_multi #(
   parameter int                N_IRQ      = 16,
   parameter int                CAUSE_BASE = 16,
   parameter logic [N_IRQ-1:0]  EDGE_MASK  = '0
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [N_IRQ-1:0]   irq_req_i,
   input  logic [N_IRQ-1:0]   mie_i,
   input  logic               gie_i,
   input  logic               exception_i,
   input  logic               mret_i,
   input  logic               stall_i,
   output logic               irq_o,
   output logic [31:0]        irq_cause_o,
   output logic [N_IRQ-1:0]   irq_ret_o,
   output logic               busy_o
);
   localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
   localparam int CW = IW + 1;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   state_e             state_q, state_d;
   logic [N_IRQ-1:0]   req_q, pend_q, pend_d;
   logic [N_IRQ-1:0]   rise, request, eligible, win_oh;
   logic [IW-1:0]      act_idx_q, act_idx_d, win_idx, start_idx;
   logic [CW-1:0]      cand;
   logic               any_elig, accept, found;

   function automatic logic [31:0] code(input logic [IW-1:0] idx);
      return {1'b1, 31'(CAUSE_BASE + int'(idx))};
   endfunction

   assign rise     = irq_req_i & ~req_q & EDGE_MASK;
   assign request  = (pend_q & EDGE_MASK) | (irq_req_i & ~EDGE_MASK);
   assign eligible = request & mie_i & {N_IRQ{gie_i}};
   assign any_elig = |eligible;
   assign accept   = (state_q == IDLE) && any_elig && !exception_i && !stall_i;

`ifdef IRQ_PRIO_RR_EN
   logic [IW-1:0] last_idx_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)     last_idx_q <= IW'(N_IRQ - 1);
      else if (accept) last_idx_q <= win_idx;
   end

   assign start_idx = (last_idx_q == IW'(N_IRQ - 1)) ? '0 : last_idx_q + 1'b1;
`else
   assign start_idx = '0;
`endif

   // Wrapping search from start_idx; with start_idx = 0 this is plain lowest-index priority.
   always_comb begin
      win_idx = '0;
      found   = 1'b0;
      cand    = '0;
      win_oh  = '0;
      for (int k = 0; k < N_IRQ; k++) begin
         cand = {1'b0, start_idx} + CW'(k);
         if (cand >= CW'(N_IRQ)) cand = cand - CW'(N_IRQ);
         if (!found && eligible[cand[IW-1:0]]) begin
            win_idx = cand[IW-1:0];
            found   = 1'b1;
         end
      end
      win_oh[win_idx] = 1'b1;
   end

   // A fresh edge in the clearing cycle re-sets the bit, so the edge is never lost.
   always_comb begin
      pend_d    = (pend_q & ~(accept ? (win_oh & EDGE_MASK) : '0)) | rise;
      act_idx_d = accept ? win_idx : act_idx_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         req_q     <= '0;
         pend_q    <= '0;
         act_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= irq_req_i;
         pend_q    <= pend_d;
         act_idx_q <= act_idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = BUSY;
         BUSY:    if (mret_i && !stall_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      irq_o       = 1'b0;
      irq_cause_o = '0;
      irq_ret_o   = '0;
      busy_o      = 1'b0;
      case (state_q)
         IDLE: begin
            irq_o = any_elig && !exception_i;
            if (any_elig) irq_cause_o = code(win_idx);
         end
         BUSY: begin
            busy_o      = 1'b1;
            irq_cause_o = code(act_idx_q);
            if (mret_i && !stall_i) irq_ret_o[act_idx_q] = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl_multi.sv
// Directed vector bench for irq_ctrl_multi (16 channels, channels 1 and 5 edge-triggered).
module tb_irq_ctrl_multi;
   localparam int          N = 16;
   localparam logic [15:0] EMASK = 16'h0022;

   localparam logic [31:0] C0 = 32'h8000_0010;
   localparam logic [31:0] C1 = 32'h8000_0011;
   localparam logic [31:0] C2 = 32'h8000_0012;
   localparam logic [31:0] C3 = 32'h8000_0013;
   localparam logic [31:0] C5 = 32'h8000_0015;
   localparam logic [31:0] C7 = 32'h8000_0017;
`ifdef IRQ_PRIO_RR_EN
   localparam logic [31:0] C_2ND = C7;
   localparam logic [15:0] R_2ND = 16'h0080;
`else
   localparam logic [31:0] C_2ND = C2;
   localparam logic [15:0] R_2ND = 16'h0004;
`endif

   typedef struct {
      logic [15:0] req;
      logic [15:0] mie;
      logic        gie;
      logic        exc;
      logic        mret;
      logic        stall;
      logic        irq;
      logic [31:0] cause;
      logic [15:0] ret;
      logic        busy;
   } vec_t;

   logic        clk, rst_n;
   logic [15:0] irq_req, mie;
   logic        gie, exc, mret, stall;
   logic        irq_o, busy_o;
   logic [31:0] irq_cause_o;
   logic [15:0] irq_ret_o;

   int   n_vec = 0;
   int   n_err = 0;
   vec_t tbl[30];

   irq_ctrl_multi #(.N_IRQ(N), .CAUSE_BASE(16), .EDGE_MASK(EMASK)) dut (
      .clk_i(clk), .rst_ni(rst_n), .irq_req_i(irq_req), .mie_i(mie), .gie_i(gie),
      .exception_i(exc), .mret_i(mret), .stall_i(stall), .irq_o(irq_o),
      .irq_cause_o(irq_cause_o), .irq_ret_o(irq_ret_o), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [15:0] req, input logic [15:0] m, input logic g,
                               input logic e, input logic mr, input logic st, input logic i,
                               input logic [31:0] c, input logic [15:0] r, input logic b);
      vec_t v;
      v.req = req; v.mie = m; v.gie = g; v.exc = e; v.mret = mr; v.stall = st;
      v.irq = i; v.cause = c; v.ret = r; v.busy = b;
      return v;
   endfunction

   // Called at a falling edge: drive, settle, compare, then advance to the next falling edge.
   task automatic apply(input vec_t v, input string name);
      irq_req = v.req; mie = v.mie; gie = v.gie; exc = v.exc; mret = v.mret; stall = v.stall;
      #1;
      n_vec++;
      if (irq_o !== v.irq || irq_cause_o !== v.cause || irq_ret_o !== v.ret || busy_o !== v.busy) begin
         n_err++;
         $display("FAIL %s: got irq=%0b cause=%h ret=%h busy=%0b, expected irq=%0b cause=%h ret=%h busy=%0b",
                  name, irq_o, irq_cause_o, irq_ret_o, busy_o, v.irq, v.cause, v.ret, v.busy);
      end
      @(negedge clk);
   endtask

   initial begin
      // req mie gie exc mret stall | irq cause ret busy
      tbl[0]  = mk(16'h0008, 16'h0008, 1, 0, 0, 0, 1, C3, 16'h0000, 0);
      tbl[1]  = mk(16'h0008, 16'h0008, 1, 0, 0, 0, 0, C3, 16'h0000, 1);
      tbl[2]  = mk(16'h0008, 16'h0008, 1, 0, 1, 0, 0, C3, 16'h0008, 1);
      tbl[3]  = mk(16'h0000, 16'h0008, 1, 0, 0, 0, 0, '0, 16'h0000, 0);
      tbl[4]  = mk(16'h0000, 16'h0008, 1, 0, 1, 0, 0, '0, 16'h0000, 0);
      tbl[5]  = mk(16'h0001, 16'h0001, 1, 1, 0, 0, 0, C0, 16'h0000, 0);
      tbl[6]  = mk(16'h0001, 16'h0001, 1, 0, 0, 0, 1, C0, 16'h0000, 0);
      tbl[7]  = mk(16'h0000, 16'h0001, 1, 0, 0, 0, 0, C0, 16'h0000, 1);
      tbl[8]  = mk(16'h0000, 16'h0001, 1, 0, 1, 0, 0, C0, 16'h0001, 1);
      tbl[9]  = mk(16'h0000, 16'h0001, 1, 0, 0, 0, 0, '0, 16'h0000, 0);
      tbl[10] = mk(16'h0001, 16'h0001, 1, 0, 0, 1, 1, C0, 16'h0000, 0);
      tbl[11] = mk(16'h0001, 16'h0001, 1, 0, 0, 1, 1, C0, 16'h0000, 0);
      tbl[12] = mk(16'h0001, 16'h0001, 1, 0, 0, 0, 1, C0, 16'h0000, 0);
      tbl[13] = mk(16'h0000, 16'h0001, 1, 0, 0, 0, 0, C0, 16'h0000, 1);
      tbl[14] = mk(16'h0000, 16'h0001, 1, 0, 1, 1, 0, C0, 16'h0000, 1);
      tbl[15] = mk(16'h0000, 16'h0001, 1, 0, 1, 1, 0, C0, 16'h0000, 1);
      tbl[16] = mk(16'h0000, 16'h0001, 1, 0, 1, 0, 0, C0, 16'h0001, 1);
      tbl[17] = mk(16'h0000, 16'h0001, 1, 0, 0, 0, 0, '0, 16'h0000, 0);
      tbl[18] = mk(16'h0001, 16'h0001, 0, 0, 0, 0, 0, '0, 16'h0000, 0);
      tbl[19] = mk(16'h0001, 16'h0000, 1, 0, 0, 0, 0, '0, 16'h0000, 0);
      tbl[20] = mk(16'h0080, 16'h0084, 1, 0, 0, 1, 1, C7, 16'h0000, 0);
      tbl[21] = mk(16'h0084, 16'h0084, 1, 0, 0, 1, 1, C2, 16'h0000, 0);
      tbl[22] = mk(16'h0000, 16'h0084, 1, 0, 0, 0, 0, '0, 16'h0000, 0);
      tbl[23] = mk(16'h0084, 16'h0084, 1, 0, 0, 0, 1, C2, 16'h0000, 0);
      tbl[24] = mk(16'h0084, 16'h0084, 1, 0, 0, 0, 0, C2, 16'h0000, 1);
      tbl[25] = mk(16'h0084, 16'h0084, 1, 0, 1, 0, 0, C2, 16'h0004, 1);
      tbl[26] = mk(16'h0084, 16'h0084, 1, 0, 0, 0, 1, C_2ND, 16'h0000, 0);
      tbl[27] = mk(16'h0000, 16'h0084, 1, 0, 0, 0, 0, C_2ND, 16'h0000, 1);
      tbl[28] = mk(16'h0000, 16'h0084, 1, 0, 1, 0, 0, C_2ND, R_2ND, 1);
      tbl[29] = mk(16'h0000, 16'h0084, 1, 0, 0, 0, 0, '0, 16'h0000, 0);

      rst_n = 1'b0;
      irq_req = '0; mie = '0; gie = 1'b0; exc = 1'b0; mret = 1'b0; stall = 1'b0;
      @(negedge clk);
      apply(mk(16'h0000, 16'h0000, 0, 0, 0, 0, 0, '0, 16'h0000, 0), "reset");
      rst_n = 1'b1;

      for (int i = 0; i < 30; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

      // edge ch5 pulses while masked, enabled ten cycles later
      apply(mk(16'h0020, 16'h0000, 1, 0, 0, 0, 0, '0, 16'h0000, 0), "e5_pulse");
      for (int i = 0; i < 9; i++)
         apply(mk(16'h0000, 16'h0000, 1, 0, 0, 0, 0, '0, 16'h0000, 0), $sformatf("e5_masked%0d", i));
      apply(mk(16'h0000, 16'h0020, 1, 0, 0, 0, 1, C5, 16'h0000, 0), "e5_fire");
      apply(mk(16'h0000, 16'h0020, 1, 0, 0, 0, 0, C5, 16'h0000, 1), "e5_busy");
      apply(mk(16'h0000, 16'h0020, 1, 0, 1, 0, 0, C5, 16'h0020, 1), "e5_mret");
      apply(mk(16'h0000, 16'h0020, 1, 0, 0, 0, 0, '0, 16'h0000, 0), "e5_cleared");
      apply(mk(16'h0000, 16'h0020, 1, 0, 0, 0, 0, '0, 16'h0000, 0), "e5_quiet");

      // edge ch1 re-arrives during its own handler
      apply(mk(16'h0002, 16'h0002, 1, 0, 0, 0, 0, '0, 16'h0000, 0), "e1_pulse");
      apply(mk(16'h0000, 16'h0002, 1, 0, 0, 0, 1, C1, 16'h0000, 0), "e1_fire");
      apply(mk(16'h0002, 16'h0002, 1, 0, 0, 0, 0, C1, 16'h0000, 1), "e1_rearm");
      apply(mk(16'h0000, 16'h0002, 1, 0, 0, 0, 0, C1, 16'h0000, 1), "e1_busy");
      apply(mk(16'h0000, 16'h0002, 1, 0, 1, 0, 0, C1, 16'h0002, 1), "e1_mret");
      apply(mk(16'h0000, 16'h0002, 1, 0, 0, 0, 1, C1, 16'h0000, 0), "e1_refire");
      apply(mk(16'h0000, 16'h0002, 1, 0, 0, 0, 0, C1, 16'h0000, 1), "e1_busy2");
      apply(mk(16'h0000, 16'h0002, 1, 0, 1, 0, 0, C1, 16'h0002, 1), "e1_mret2");
      apply(mk(16'h0000, 16'h0002, 1, 0, 0, 0, 0, '0, 16'h0000, 0), "e1_idle");

      // new edge in the very cycle its pend bit is cleared
      apply(mk(16'h0002, 16'h0002, 1, 0, 0, 0, 0, '0, 16'h0000, 0), "sw_pulse");
      apply(mk(16'h0000, 16'h0002, 1, 0, 0, 1, 1, C1, 16'h0000, 0), "sw_stall");
      apply(mk(16'h0002, 16'h0002, 1, 0, 0, 0, 1, C1, 16'h0000, 0), "sw_accept");
      apply(mk(16'h0002, 16'h0002, 1, 0, 0, 0, 0, C1, 16'h0000, 1), "sw_busy");
      apply(mk(16'h0000, 16'h0002, 1, 0, 1, 0, 0, C1, 16'h0002, 1), "sw_mret");
      apply(mk(16'h0000, 16'h0002, 1, 0, 0, 0, 1, C1, 16'h0000, 0), "sw_kept");
      apply(mk(16'h0000, 16'h0002, 1, 0, 1, 0, 0, C1, 16'h0002, 1), "sw_mret2");
      apply(mk(16'h0000, 16'h0002, 1, 0, 0, 0, 0, '0, 16'h0000, 0), "sw_idle");

      // reset while busy, with an edge pending on ch5
      apply(mk(16'h0008, 16'h0008, 1, 0, 0, 0, 1, C3, 16'h0000, 0), "rb_fire");
      apply(mk(16'h0028, 16'h0008, 1, 0, 0, 0, 0, C3, 16'h0000, 1), "rb_busy");
      apply(mk(16'h0008, 16'h0008, 1, 0, 0, 0, 0, C3, 16'h0000, 1), "rb_busy2");
      rst_n = 1'b0;
      apply(mk(16'h0000, 16'h0000, 1, 0, 0, 0, 0, '0, 16'h0000, 0), "rb_reset");
      rst_n = 1'b1;
      apply(mk(16'h0000, 16'h0020, 1, 0, 0, 0, 0, '0, 16'h0000, 0), "rb_pend_lost");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
